// File: rtl/twiddle_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_gen_if
// Brief    : Request / sequence / output bundle for the twiddle generator.
// Revision : 1.0  initial release
// ============================================================================
interface twiddle_gen_if #(
    parameter int LOG2N = 6,
    parameter int W     = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [LOG2N-1:0] idx;
    logic             inv;
    logic             seq_start;
    logic [LOG2N-1:0] seq_stride;
    logic [LOG2N:0]   seq_len;
    logic             seq_inv;
    logic             seq_busy;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     tw_re;
    logic [W-1:0]     tw_im;
    logic             out_last;

    modport master (
        output in_valid, idx, inv, seq_start, seq_stride, seq_len, seq_inv, out_ready,
        input  in_ready, seq_busy, out_valid, tw_re, tw_im, out_last
    );

    modport slave (
        input  in_valid, idx, inv, seq_start, seq_stride, seq_len, seq_inv, out_ready,
        output in_ready, seq_busy, out_valid, tw_re, tw_im, out_last
    );
endinterface
`default_nettype wire

// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_gen
// Brief    : FFT twiddle generator from a quarter-wave cosine table, 2-stage.
// Revision : 1.0  initial release
// ============================================================================
module twiddle_gen #(
    parameter int LOG2N = 6,
    parameter int W     = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    twiddle_gen_if.slave    bus
);
    localparam int         c_n       = 1 << LOG2N;
    localparam int         c_q       = c_n / 4;
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_seq  = 1'b1;

    function automatic logic [W-1:0] f_cos_q(input int m);
        real v;
        v = $cos(2.0 * 3.141592653589793 * real'(m) / real'(c_n)) * (2.0 ** (W - 2));
        return W'($rtoi(v + 0.5));
    endfunction

    logic [W-1:0] w_rom [0:c_q];

    for (genvar m = 0; m <= c_q; m++) begin : g_rom
        localparam logic [W-1:0] c_val = f_cos_q(m);
        assign w_rom[m] = c_val;
    end

    logic [0:0]       r_state, w_state_nx;
    logic [LOG2N-1:0] r_acc, w_acc_nx;
    logic [LOG2N:0]   r_cnt, w_cnt_nx;
    logic [LOG2N-1:0] r_stride, w_stride_nx;
    logic [LOG2N:0]   r_len, w_len_nx;
    logic             r_seq_inv, w_seq_inv_nx;

    logic             w_en, w_in_ready, w_issue, w_inv, w_last;
    logic [LOG2N-1:0] w_idx;
    logic [1:0]       w_q;
    logic [LOG2N-2:0] w_r, w_rc;
    logic [W-1:0]     w_mag_re, w_mag_im;
    logic             w_neg_re, w_neg_im;

    logic             r_s1_valid, r_s1_last, r_s1_neg_re, r_s1_neg_im;
    logic [W-1:0]     r_s1_re, r_s1_im;
    logic             r_out_valid, r_out_last;
    logic [W-1:0]     r_tw_re, r_tw_im;

    // Issue selection and sequencer next-state
    always_comb begin
        w_en          = !r_out_valid || bus.out_ready;
        w_in_ready    = w_en && (r_state == c_st_idle) && !reset;
        w_state_nx    = r_state;
        w_acc_nx      = r_acc;
        w_cnt_nx      = r_cnt;
        w_stride_nx   = r_stride;
        w_len_nx      = r_len;
        w_seq_inv_nx  = r_seq_inv;
        w_issue       = 1'b0;
        w_idx         = bus.idx;
        w_inv         = bus.inv;
        w_last        = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_issue = bus.in_valid && w_in_ready;
                if (bus.seq_start && (bus.seq_len != '0)) begin
                    w_state_nx   = c_st_seq;
                    w_stride_nx  = bus.seq_stride;
                    w_len_nx     = bus.seq_len;
                    w_seq_inv_nx = bus.seq_inv;
                    w_acc_nx     = '0;
                    w_cnt_nx     = '0;
                end
            end
            default: begin
                if (w_en) begin
                    w_issue  = 1'b1;
                    w_idx    = r_acc;
                    w_inv    = r_seq_inv;
                    w_last   = (r_cnt == r_len - 1'b1);
                    w_acc_nx = r_acc + r_stride;
                    w_cnt_nx = r_cnt + 1'b1;
                    if (w_last) begin
                        w_state_nx = c_st_idle;
                    end
                end
            end
        endcase
    end

    // Quadrant fold: odd quadrants swap the table operands
    always_comb begin
        w_q      = w_idx[LOG2N-1 -: 2];
        w_r      = {1'b0, w_idx[LOG2N-3:0]};
        w_rc     = (LOG2N-1)'(c_q) - w_r;
        w_mag_re = w_q[0] ? w_rom[w_rc] : w_rom[w_r];
        w_mag_im = w_q[0] ? w_rom[w_r]  : w_rom[w_rc];
        w_neg_re = w_q[1] ^ w_q[0];
        w_neg_im = ~w_q[1] ^ w_inv;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_stride    <= '0;
            r_len       <= '0;
            r_seq_inv   <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_neg_re <= 1'b0;
            r_s1_neg_im <= 1'b0;
            r_s1_re     <= '0;
            r_s1_im     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_tw_re     <= '0;
            r_tw_im     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_acc     <= w_acc_nx;
            r_cnt     <= w_cnt_nx;
            r_stride  <= w_stride_nx;
            r_len     <= w_len_nx;
            r_seq_inv <= w_seq_inv_nx;
            if (w_en) begin
                r_s1_valid  <= w_issue;
                r_s1_last   <= w_last;
                r_s1_neg_re <= w_neg_re;
                r_s1_neg_im <= w_neg_im;
                r_s1_re     <= w_mag_re;
                r_s1_im     <= w_mag_im;
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_last;
                r_tw_re     <= r_s1_neg_re ? -r_s1_re : r_s1_re;
                r_tw_im     <= r_s1_neg_im ? -r_s1_im : r_s1_im;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.seq_busy  = (r_state == c_st_seq);
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.tw_re     = r_tw_re;
    assign bus.tw_im     = r_tw_im;
endmodule
`default_nettype wire

// File: doc/twiddle_gen.md
TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 The parameter LOG2N SHALL default to 6 and set the FFT size N = 2^LOG2N, with legal values 3..12.
REQ-002 The parameter W SHALL default to 16 and set the twiddle word width; outputs SHALL be signed fixed point (W, W-2).
REQ-003 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-004 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  external index request valid
- in_ready  out  1  request accepted this cycle when high together with in_valid
- idx  in  LOG2N  twiddle index k
- inv  in  1  1 selects conjugate twiddle (IFFT)
- seq_start  in  1  pulse that launches internal sequence mode
- seq_stride  in  LOG2N  index step in sequence mode
- seq_len  in  LOG2N+1  number of sequence outputs
- seq_inv  in  1  inv value applied to the whole sequence
- seq_busy  out  1  sequence mode active
- out_valid  out  1  twiddle valid
- out_ready  in  1  downstream accept
- tw_re  out  W  cos(2*pi*k/N)
- tw_im  out  W  -sin(2*pi*k/N), or +sin when inv=1
- out_last  out  1  marks the final sequence element

Function
REQ-005 The storage SHALL be a quarter-wave table c[m] = round-half-away(cos(2*pi*m/N) * 2^(W-2)) for m = 0..N/4, built at elaboration; no full-period table SHALL exist.
REQ-006 Quadrant folding SHALL use q = k[LOG2N-1:LOG2N-2], r = remaining bits, and Q = N/4:
- q0: re = c[r], im = -c[Q-r]
- q1: re = -c[Q-r], im = -c[r]
- q2: re = -c[r], im = +c[Q-r]
- q3: re = c[Q-r], im = +c[r]
REQ-007 When inv=1, the block SHALL negate im after folding; -c[0] SHALL be representable (0xC000 at W=16), and no saturation is needed.
REQ-008 The datapath SHALL be a two-stage pipeline:
- S1 registers the table reads, negate flags, and the last flag.
- S2 applies the negation and registers tw_re, tw_im, out_valid, and out_last.
REQ-009 Latency SHALL be exactly 2 cycles from acceptance to out_valid when there is no stall, with throughput of 1 per cycle.
REQ-010 The pipeline enable SHALL be en = !out_valid || out_ready; when en=0, all stage registers SHALL hold, and outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-011 in_ready SHALL equal en && (state == IDLE); in_valid SHALL be ignored while seq_busy=1.
REQ-012 The FSM SHALL have states IDLE and SEQ:
- IDLE to SEQ on seq_start=1 with seq_len != 0, capturing stride, len, and seq_inv, and setting acc = 0 and cnt = 0.
- seq_start with seq_len = 0 SHALL be ignored.
- seq_start in SEQ SHALL be ignored.
REQ-013 In SEQ, each cycle with en=1 SHALL issue idx = acc, then set acc = (acc + stride) mod N (wrap-around by width truncation) and cnt = cnt + 1.
REQ-014 The element issued with cnt = len-1 SHALL carry last=1, and the FSM SHALL return to IDLE in the same cycle that element is issued.
REQ-015 seq_busy SHALL be high exactly while state == SEQ.
REQ-016 seq_len = N SHALL be legal and SHALL produce N outputs.
REQ-017 A simultaneous seq_start and in_valid in IDLE SHALL accept the external request that cycle; the sequence SHALL begin on the next cycle.
REQ-018 out_last SHALL be 0 for all externally requested indices.

Reset
REQ-019 On reset, the block SHALL set out_valid, out_last, seq_busy, tw_re, and tw_im to 0, clear all S1 valid and data registers, and set state = IDLE with acc = 0 and cnt = 0.
REQ-020 Reset mid-sequence or mid-stall SHALL discard all in-flight elements, and no partial sequence SHALL resume after reset.
REQ-021 in_ready SHALL be 0 during reset and 1 in the first cycle after reset deasserts.

Verification (LOG2N=6, W=16)
REQ-022 The bench SHALL cover the following scenarios:
- idx=1, inv=0 accepted at cycle t -> at t+2, out_valid=1, tw_re=0x3FB1, tw_im=0xF9BA.
- idx=48 -> tw_re=0x0000, tw_im=0x4000; idx=32 -> tw_re=0xC000, tw_im=0x0000; idx=1, inv=1 -> tw_im=0x0646.
- Stream idx 0,1,2 with out_ready=0 for 3 cycles after the first output -> tw_re holds 0x4000, in_ready=0, then all three are delivered in order with no loss or duplication.
- seq_start with stride=5, len=14 -> indices 0,5,...,60,1 in order; out_last=1 only on idx 1; seq_busy drops after the 14th issue.
- Reset asserted at the 4th cycle of a len=10 sequence -> next cycle out_valid=0, seq_busy=0, and no further outputs appear.
- Sweep k=0..63 with inv=0 and inv=1 -> every output is within 1 LSB of the ideal cos/sin values, the inv=1 im equals the negated inv=0 im, and quadrant symmetries hold exactly.
